// File: rtl/tl_pkg.sv
// rtl/tl_pkg.sv - lamp and phase codes shared by the traffic light scheduler
package tl_pkg;

  typedef enum logic [1:0] {
    GREEN  = 2'b00,
    YELLOW = 2'b01,
    LEFT   = 2'b10,
    RED    = 2'b11
  } lamp_e;

  typedef enum logic [3:0] {
    S0_A_GRN  = 4'd0,
    S1_A_YEL  = 4'd1,
    S2_A_LFT  = 4'd2,
    S3_A_LYEL = 4'd3,
    S4_B_GRN  = 4'd4,
    S5_B_YEL  = 4'd5,
    S6_B_LFT  = 4'd6,
    S7_B_LYEL = 4'd7,
    S8_WALK   = 4'd8,
    S9_EMG    = 4'd9
  } phase_e;

endpackage

// File: rtl/tl_phase_timer.sv
// rtl/tl_phase_timer.sv - per-phase cycle counter, cleared on phase change, saturating
module tl_phase_timer #(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/tl_phase_sched.sv
// rtl/tl_phase_sched.sv - timed A/B phase scheduler with left turns, walk phase and emergency preempt
module tl_phase_sched
  import tl_pkg::*;
#(
  parameter int YELLOW_CYC = 3,
  parameter int MIN_GREEN  = 5,
  parameter int MAX_GREEN  = 20,
  parameter int WALK_CYC   = 4,
  parameter int CNT_W      = 5
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       Ta,
  input  logic       Tal,
  input  logic       Tb,
  input  logic       Tbl,
  input  logic       ped_req,
  input  logic       emg,
  output logic [1:0] La,
  output logic [1:0] Lb,
  output logic       ped_walk,
  output logic [3:0] phase
);

  localparam logic [CNT_W-1:0] YEL_END  = CNT_W'(YELLOW_CYC - 1);
  localparam logic [CNT_W-1:0] MIN_END  = CNT_W'(MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] MAX_END  = CNT_W'(MAX_GREEN - 1);
  localparam logic [CNT_W-1:0] WALK_END = CNT_W'(WALK_CYC - 1);

  phase_e           state_q, state_d;
  logic             ped_q, ped_d;
  logic [CNT_W-1:0] t;
  logic             phase_chg;
  logic             min_met, max_hit, yel_done, walk_done;
  phase_e           eoc_target;

  tl_phase_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clr_i   (phase_chg),
    .cnt_o   (t)
  );

  assign min_met    = (t >= MIN_END);
  assign max_hit    = (t >= MAX_END);
  assign yel_done   = (t >= YEL_END);
  assign walk_done  = (t >= WALK_END);
  assign eoc_target = ped_q ? S8_WALK : S0_A_GRN;

  // Green/left exit: emergency first, then the hard maximum, then gap-out on an idle sensor.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S0_A_GRN:  if (emg || max_hit || (min_met && !Ta))  state_d = S1_A_YEL;
      S2_A_LFT:  if (emg || max_hit || (min_met && !Tal)) state_d = S3_A_LYEL;
      S4_B_GRN:  if (emg || max_hit || (min_met && !Tb))  state_d = S5_B_YEL;
      S6_B_LFT:  if (emg || max_hit || (min_met && !Tbl)) state_d = S7_B_LYEL;
      S1_A_YEL: begin
        if (yel_done) begin
          if (emg)      state_d = S9_EMG;
          else if (Tal) state_d = S2_A_LFT;
          else          state_d = S4_B_GRN;
        end
      end
      S3_A_LYEL: begin
        if (yel_done) state_d = emg ? S9_EMG : S4_B_GRN;
      end
      S5_B_YEL: begin
        if (yel_done) begin
          if (emg)      state_d = S9_EMG;
          else if (Tbl) state_d = S6_B_LFT;
          else          state_d = eoc_target;
        end
      end
      S7_B_LYEL: begin
        if (yel_done) state_d = emg ? S9_EMG : eoc_target;
      end
      S8_WALK: begin
        if (emg)            state_d = S9_EMG;
        else if (walk_done) state_d = S0_A_GRN;
      end
      S9_EMG: begin
        if (!emg) state_d = S0_A_GRN;
      end
      default: state_d = S9_EMG;
    endcase
  end

  assign phase_chg = (state_d != state_q);

  // Entering the walk consumes the request; a request during the walk re-arms it.
  always_comb begin
    ped_d = ped_q | ped_req;
    if (state_d == S8_WALK && state_q != S8_WALK) begin
      ped_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S0_A_GRN;
      ped_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ped_q   <= ped_d;
    end
  end

  always_comb begin
    La       = RED;
    Lb       = RED;
    ped_walk = 1'b0;
    case (state_q)
      S0_A_GRN:  La = GREEN;
      S1_A_YEL:  La = YELLOW;
      S2_A_LFT:  La = LEFT;
      S3_A_LYEL: La = YELLOW;
      S4_B_GRN:  Lb = GREEN;
      S5_B_YEL:  Lb = YELLOW;
      S6_B_LFT:  Lb = LEFT;
      S7_B_LYEL: Lb = YELLOW;
      S8_WALK:   ped_walk = 1'b1;
      default:   ;
    endcase
  end

  assign phase = state_q;

endmodule

// File: tb/tb_tl_phase_sched.sv
// tb/tb_tl_phase_sched.sv - directed and randomized bench for tl_phase_sched against a phase-rule model
module tb_tl_phase_sched;

  localparam int YEL  = 3;
  localparam int MING = 5;
  localparam int MAXG = 20;
  localparam int WALK = 4;
  localparam int TSAT = 31;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       Ta = 1'b0, Tal = 1'b0, Tb = 1'b0, Tbl = 1'b0;
  logic       ped_req = 1'b0, emg = 1'b0;
  logic [1:0] La, Lb;
  logic       ped_walk;
  logic [3:0] phase;

  int checks = 0;
  int errors = 0;

  int m_ph = 0;
  int m_t = 0;
  bit m_latch = 1'b0;

  int la_tab [10] = '{0, 1, 2, 1, 3, 3, 3, 3, 3, 3};
  int lb_tab [10] = '{3, 3, 3, 3, 0, 1, 2, 1, 3, 3};

  always #5 clk = ~clk;

  tl_phase_sched #(
    .YELLOW_CYC (YEL),
    .MIN_GREEN  (MING),
    .MAX_GREEN  (MAXG),
    .WALK_CYC   (WALK),
    .CNT_W      (5)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .Ta       (Ta),
    .Tal      (Tal),
    .Tb       (Tb),
    .Tbl      (Tbl),
    .ped_req  (ped_req),
    .emg      (emg),
    .La       (La),
    .Lb       (Lb),
    .ped_walk (ped_walk),
    .phase    (phase)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Phase rules: greens run MIN..MAX and gap out on an idle sensor, yellows and walk are fixed.
  function automatic int ref_next(int ph, int t, bit a, bit al, bit b, bit bl, bit e, bit latch);
    bit sensor;
    int eoc;
    eoc = latch ? 8 : 0;
    if (ph == 0 || ph == 2 || ph == 4 || ph == 6) begin
      sensor = (ph == 0) ? a : (ph == 2) ? al : (ph == 4) ? b : bl;
      if (e || t >= MAXG - 1 || (t >= MING - 1 && !sensor)) return ph + 1;
      return ph;
    end
    if (ph == 1 || ph == 3 || ph == 5 || ph == 7) begin
      if (t < YEL - 1) return ph;
      if (e) return 9;
      if (ph == 1) return al ? 2 : 4;
      if (ph == 3) return 4;
      if (ph == 5) return bl ? 6 : eoc;
      return eoc;
    end
    if (ph == 8) begin
      if (e) return 9;
      return (t >= WALK - 1) ? 0 : 8;
    end
    if (ph == 9) return e ? 9 : 0;
    return 9;
  endfunction

  task automatic check_outs(input string tag);
    chk({tag, "_phase"}, 32'(phase), 32'(m_ph));
    chk({tag, "_La"}, 32'(La), 32'(la_tab[m_ph]));
    chk({tag, "_Lb"}, 32'(Lb), 32'(lb_tab[m_ph]));
    chk({tag, "_walk"}, 32'(ped_walk), (m_ph == 8) ? 32'd1 : 32'd0);
  endtask

  task automatic step();
    int nph;
    @(posedge clk);
    if (reset_n) begin
      nph = ref_next(m_ph, m_t, Ta, Tal, Tb, Tbl, emg, m_latch);
      m_latch = (nph == 8 && m_ph != 8) ? 1'b0 : (m_latch | ped_req);
      m_t = (nph != m_ph) ? 0 : ((m_t < TSAT) ? m_t + 1 : TSAT);
      m_ph = nph;
    end
    #1;
    check_outs("step");
  endtask

  task automatic run_until_change(output int len, output int nph);
    logic [3:0] start;
    start = phase;
    len = 1;
    step();
    while (phase === start && len < 64) begin
      len++;
      step();
    end
    nph = int'(phase);
  endtask

  initial begin
    int len, nph;

    repeat (3) @(posedge clk);
    #1;
    check_outs("reset");
    @(negedge clk);
    reset_n = 1'b1;

    run_until_change(len, nph); chk("idle_s0_len", len, MING); chk("idle_s0_next", nph, 1);
    run_until_change(len, nph); chk("idle_s1_len", len, YEL);  chk("idle_s1_next", nph, 4);
    run_until_change(len, nph); chk("idle_s4_len", len, MING); chk("idle_s4_next", nph, 5);
    run_until_change(len, nph); chk("idle_s5_len", len, YEL);  chk("idle_s5_next", nph, 0);

    Ta = 1'b1;
    run_until_change(len, nph); chk("ta_s0_len", len, MAXG); chk("ta_s0_next", nph, 1);
    Ta = 1'b0;

    Tal = 1'b1;
    run_until_change(len, nph); chk("tal_s1_len", len, YEL); chk("tal_s1_next", nph, 2);
    repeat (6) step();
    Tal = 1'b0;
    step();
    chk("tal_s2_exit", 32'(phase), 32'd3);
    run_until_change(len, nph); chk("tal_s3_len", len, YEL); chk("tal_s3_next", nph, 4);

    ped_req = 1'b1;
    step();
    ped_req = 1'b0;
    run_until_change(len, nph); chk("ped_s4_rest", len, MING - 1); chk("ped_s4_next", nph, 5);
    run_until_change(len, nph); chk("ped_s5_len", len, YEL);  chk("ped_s5_next", nph, 8);
    run_until_change(len, nph); chk("ped_s8_len", len, WALK); chk("ped_s8_next", nph, 0);
    run_until_change(len, nph);
    run_until_change(len, nph);
    run_until_change(len, nph);
    run_until_change(len, nph); chk("ped_cleared_next", nph, 0);

    step();
    step();
    emg = 1'b1;
    step();
    chk("emg_to_yel", 32'(phase), 32'd1);
    step();
    step();
    chk("emg_yel_hold", 32'(phase), 32'd1);
    step();
    chk("emg_enter", 32'(phase), 32'd9);
    step();
    chk("emg_hold", 32'(phase), 32'd9);
    emg = 1'b0;
    step();
    chk("emg_exit", 32'(phase), 32'd0);

    run_until_change(len, nph);
    run_until_change(len, nph);
    run_until_change(len, nph); chk("rst_pre_s5", nph, 5);
    step();
    reset_n = 1'b0;
    m_ph = 0;
    m_t = 0;
    m_latch = 1'b0;
    #1;
    chk("midrst_phase", 32'(phase), 32'd0);
    chk("midrst_La", 32'(La), 32'd0);
    chk("midrst_Lb", 32'(Lb), 32'd3);
    chk("midrst_walk", 32'(ped_walk), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 3000; i++) begin
      Ta      = 1'($urandom_range(0, 1));
      Tal     = 1'($urandom_range(0, 1));
      Tb      = ($urandom_range(0, 3) != 0);
      Tbl     = 1'($urandom_range(0, 1));
      ped_req = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 39) == 0) emg = ~emg;
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
